// File: rtl/fb_pkg.sv
// fb_pkg: shared types and defaults for the frame-buffer scanout path.
// Holds the scan FSM state enum, default geometry constants and the
// FIFO entry layout (pixel word plus start/end-of-frame tags).
package fb_pkg;

  localparam int FB_ADDR_W      = 13;
  localparam int FB_DATA_W      = 16;
  localparam int FB_FRAME_WORDS = 8192;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

  // One queued pixel; the tags travel with the word so the head of the
  // FIFO carries everything the stream interface needs.
  typedef struct packed {
    logic [FB_DATA_W-1:0] data;
    logic                 sof;
    logic                 eof;
  } fifo_entry_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// fb_sync_fifo: single-clock FIFO with occupancy count.
// Head entry is read straight from the storage register at rd_ptr, so
// rdata holds steady until a pop. DEPTH must be a power of two >= 2.
// Storage is cleared on reset so rdata reads as zero out of reset.
module fb_sync_fifo #(
  parameter  int W     = 18,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only safe when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr];

  // Storage, pointers and count; push and pop together leave count as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Upstream credit accounting must never let a push hit a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: streams one frame out of memory port 2 as a valid/ready
// pixel stream with start/end-of-frame marks.
// Reads are issued only when the skid FIFO has room for every word
// already in flight, so read latency never causes overflow and the
// stream runs at one word per cycle while out_ready stays high.
// Optional: define FB_SCAN_BANK_EN to add bank_sel; the bank is latched
// on an accepted start and drives the address MSB for the whole frame.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk_clk,
  input  logic              rst_reset,
  input  logic              start,
`ifdef FB_SCAN_BANK_EN
  input  logic              bank_sel,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof
);

  localparam int                CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int                ENTRY_W = $bits(fifo_entry_t);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(FRAME_WORDS - 1);

  scan_state_e           state;
  logic [ADDR_W-1:0]     rd_cnt;
  logic                  issue, pop;
  logic [RD_LATENCY:1]   vld_pipe, sof_pipe, eof_pipe;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [7:0]            committed;
  fifo_entry_t           push_entry, head_entry;

  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 2'b11;

  assign pop = out_valid && out_ready;
  // Words that will occupy the FIFO once everything in flight lands,
  // net of the beat leaving this cycle.
  assign committed = 8'(fifo_count) + 8'($countones(vld_pipe)) - 8'(pop);
  assign issue     = (state == FETCH) && (committed < 8'(FIFO_DEPTH));
  assign mem_chipselect = issue;

`ifdef FB_SCAN_BANK_EN
  logic bank_q;
  assign mem_address = {bank_q, rd_cnt[ADDR_W-2:0]};

  // Bank is captured only when a frame is accepted, then held.
  always_ff @(posedge clk_clk) begin
    if (rst_reset)                       bank_q <= 1'b0;
    else if (state == IDLE && start)     bank_q <= bank_sel;
  end
`else
  assign mem_address = rd_cnt;
`endif

  // Scan FSM: accept start, walk addresses under FIFO credit, drain.
  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      rd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= FETCH;
            busy   <= 1'b1;
            rd_cnt <= '0;
          end
        end
        FETCH: begin
          if (issue) begin
            if (rd_cnt == LAST) begin
              state  <= DRAIN;
              rd_cnt <= '0;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Nothing in flight and the FIFO empties this cycle at the latest.
          if (committed == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency shadow: valid plus frame tags for each outstanding read.
  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      sof_pipe[1] <= issue && (rd_cnt == '0);
      eof_pipe[1] <= issue && (rd_cnt == LAST);
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        sof_pipe[i] <= sof_pipe[i-1];
        eof_pipe[i] <= eof_pipe[i-1];
      end
    end
  end

  assign push_entry.data = mem_readdata;
  assign push_entry.sof  = sof_pipe[RD_LATENCY];
  assign push_entry.eof  = eof_pipe[RD_LATENCY];

  fb_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_clk),
    .rst   (rst_reset),
    .push  (vld_pipe[RD_LATENCY]),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_entry.data;
  assign out_sof   = head_entry.sof;
  assign out_eof   = head_entry.eof;

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Downstream consumer of the frame buffer's second port (s2). Streams one full frame from it as a pixel stream with valid/ready handshake.
- Stream goes to the display driver.
- Issues sequential reads from address 0 to FRAME_WORDS-1 and absorbs the fixed memory read latency. A small skid FIFO decouples this from output backpressure.
- Marks start-of-frame and end-of-frame.

Parameters:
- ADDR_W, 13, memory word-address width.
- DATA_W, 16, memory/pixel word width.
- FRAME_WORDS, 8192, words per frame; must be <= 2**ADDR_W.
- RD_LATENCY, 2, cycles from address/chipselect to valid readdata; range 1..4.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= RD_LATENCY+1.

Ports:
- clk_clk  in  1  system clock; memory port 2 shares it.
- rst_reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse requesting a frame scan; ignored while busy.
- busy  out  1  high from accepted start until the last word leaves the stream.
- mem_address  out  ADDR_W  read address to memory port 2.
- mem_chipselect  out  1  read strobe, one word per asserted cycle.
- mem_clken  out  1  constant 1.
- mem_write  out  1  constant 0.
- mem_byteenable  out  2  constant 2'b11.
- mem_readdata  in  DATA_W  read data, valid RD_LATENCY cycles after the strobe.
- out_data  out  DATA_W  pixel word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when valid&&ready.
- out_sof  out  1  high with the first word of a frame.
- out_eof  out  1  high with word FRAME_WORDS-1.

Behaviour:
- Clock and reset: one clock (clk_clk). Reset (rst_reset) is synchronous and active-high.
- Reset values: busy=0, mem_address=0, mem_chipselect=0, out_valid=0, out_sof=0, out_eof=0, out_data=0. Reset clears the FIFO, the in-flight pipeline and all counters.
- Reset mid-frame: abandons the frame. No further reads or output beats after the reset cycle.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start=1 moves to FETCH next cycle, sets busy=1, resets the read counter to 0.
  - FETCH: issues a read (mem_chipselect=1, mem_address=rd_cnt) in any cycle where fifo_count + inflight + 1 <= FIFO_DEPTH. The credit check accounts for accepted output beats in the same cycle. rd_cnt increments on each issued read.
  - FETCH exit: after the read with rd_cnt==FRAME_WORDS-1, go to DRAIN.
  - DRAIN: no reads issued. Return to IDLE when inflight==0, fifo empty, and no beat is pending. busy drops in the same cycle as the IDLE transition, i.e. the cycle after the final handshake.
- Read pipeline: RD_LATENCY-deep valid shift register tagged with sof/eof bits. mem_readdata is captured into the FIFO when the tail bit is set.
  - Memory-to-output latency: minimum RD_LATENCY+1 cycles from strobe to out_valid with the FIFO empty.
  - Full rate: sustained throughput is 1 word/cycle when out_ready is held high.
- FIFO: registered head drives out_data/out_valid/out_sof/out_eof.
  - Simultaneous push and pop: count unchanged.
  - Overflow: impossible by the credit rule; assertion in simulation.
- Handshake: out_data, out_sof and out_eof stay stable while out_valid=1 and out_ready=0.
- start while busy: ignored, no queuing.
- Start in the same cycle busy falls: accepted, because the FSM is already in IDLE.
- Counter width: rd_cnt is ADDR_W bits with explicit terminal compare; no wrap within a frame.

Optional Feature:
- FB_SCAN_BANK_EN defined: adds input bank_sel (1 bit).
  - Sampled only on accepted start and held for the whole frame.
  - mem_address MSB = latched bank, low ADDR_W-1 bits = rd_cnt. FRAME_WORDS must be <= 2**(ADDR_W-1).
  - Lets the writer fill one half while the other half is scanned.
- Not defined: no bank_sel port; address = rd_cnt directly.

Decomposition:
- Package fb_pkg holds: FSM state enum (IDLE/FETCH/DRAIN), default ADDR_W/DATA_W/FRAME_WORDS constants, and a typedef for the FIFO entry struct {data, sof, eof}.
- One sub-module: fb_sync_fifo (synchronous FIFO with count output). It is reusable by the upstream writer stage.

Test Plan:
- Memory model preloaded with data=address. Pulse start, out_ready=1 constantly.
  - Expect 8192 beats, data 0..8191 in order, on consecutive cycles after RD_LATENCY+1 startup.
  - Expect sof only on beat 0 and eof only on beat 8191.
  - Expect busy to fall the cycle after the last beat.
- Random out_ready (50%): same data order. No overflow assertion. out_data stable while stalled. mem_chipselect never leaves more than FIFO_DEPTH words outstanding.
- out_ready=0 for 100 cycles mid-frame: exactly FIFO_DEPTH reads issued beyond the last accepted word, then chipselect=0 until ready returns.
- start pulsed again at word 100 of a frame: ignored, and the frame completes normally with 8192 beats. start on the cycle busy=0 begins a second frame.
- rst_reset at word 3000: on the next cycle out_valid=0, busy=0, chipselect=0. A subsequent start rescans from address 0.
- FB_SCAN_BANK_EN, FRAME_WORDS=4096:
  - bank_sel=1 at start: addresses 4096..8191.
  - Toggling bank_sel mid-frame does not change the addresses.
